// File: rtl/vliw_issue_scoreboard.sv
// Issue/hazard controller: accepts decoded ALU+MEM bundles, tracks the pending load destination, runs the data-memory handshake and raises exceptions/redirects.
// Latency: alu_we and mem_we are combinational in the accept/ack cycle; mem_req, pc_redirect, exception and busy_mask update one cycle after accept.
// Backpressure: issue_ready drops outside IDLE (memory in flight or flush) and on any busy-register hazard; bundles are held by the decoder until accepted.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   issue_valid / issue_ready     bundle handshake; pc is the bundle PC
//   alu_* / mem_* / mem* / is*    decoded slot fields and controls
//   branch_taken, branch_target   branch condition and target
//   alu_we, mem_we, mem_wb_rd     gated register-file write enables and load destination
//   mem_req, mem_we_cmd, mem_ack  single-outstanding data-memory handshake
//   pc_redirect, redirect_addr    one-cycle redirect pulse and target
//   exception, epc                one-cycle exception pulse and faulting PC
//   busy_mask                     pending-load scoreboard, one bit per register
module vliw_issue_scoreboard #(
  parameter logic [31:0] EXC_ADDR    = 32'h00FF00FF,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] pc,
  input  logic [2:0]  alu_rm,
  input  logic [2:0]  alu_rn,
  input  logic [2:0]  alu_rd,
  input  logic        alu_regWrite,
  input  logic        alu_undefinedInstruction,
  input  logic [2:0]  mem_rn,
  input  logic [2:0]  mem_rd,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        mem_regWrite,
  input  logic        isBranch,
  input  logic        isJump,
  input  logic        mem_undefinedInstruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        alu_we,
  output logic        mem_we,
  output logic [2:0]  mem_wb_rd,
  output logic        mem_req,
  output logic        mem_we_cmd,
  input  logic        mem_ack,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        exception,
  output logic [31:0] epc,
  output logic [7:0]  busy_mask
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  // Counter value seen in the last permitted wait cycle; a miss there times out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  busy_q;
  logic        mem_req_q;
  logic        mem_we_cmd_q;
  logic [2:0]  mem_rd_q;
  logic [31:0] mem_pc_q;
  logic [7:0]  cnt_q;
  logic        pc_redirect_q;
  logic [31:0] redirect_addr_q;
  logic        exception_q;
  logic [31:0] epc_q;

  logic hazard;
  logic accept;
  logic fault;
  logic take_redirect;
  logic mem_op;
  logic mem_done;

  always_comb begin
    hazard = busy_q[alu_rm] | busy_q[alu_rn] | busy_q[mem_rn]
           | (memWrite & busy_q[mem_rd])
           | (alu_regWrite & busy_q[alu_rd]);
    fault = alu_undefinedInstruction | mem_undefinedInstruction
          | (alu_regWrite & mem_regWrite & (alu_rd == mem_rd));
    take_redirect = isJump | (isBranch & branch_taken);
    mem_op        = memRead | memWrite;
    issue_ready   = ~reset & (state_q == S_IDLE) & ~hazard;
    accept        = issue_valid & issue_ready;
    // A faulting bundle must not touch the register file.
    alu_we        = accept & ~fault & alu_regWrite;
    // Acks outside MEM_WAIT are ignored; a store completion never writes back.
    mem_done      = ~reset & (state_q == S_MEM_WAIT) & mem_ack;
    mem_we        = mem_done & ~mem_we_cmd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      busy_q          <= '0;
      mem_req_q       <= 1'b0;
      mem_we_cmd_q    <= 1'b0;
      mem_rd_q        <= '0;
      mem_pc_q        <= '0;
      cnt_q           <= '0;
      pc_redirect_q   <= 1'b0;
      redirect_addr_q <= '0;
      exception_q     <= 1'b0;
      epc_q           <= '0;
    end else begin
      // Redirect and exception are single-cycle pulses.
      pc_redirect_q <= 1'b0;
      exception_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (fault) begin
              exception_q     <= 1'b1;
              pc_redirect_q   <= 1'b1;
              redirect_addr_q <= EXC_ADDR;
              epc_q           <= pc;
              state_q         <= S_FLUSH;
            end else if (take_redirect) begin
              // Control transfer wins; such a bundle carries no memory op.
              pc_redirect_q   <= 1'b1;
              redirect_addr_q <= branch_target;
              state_q         <= S_FLUSH;
            end else if (mem_op) begin
              mem_req_q    <= 1'b1;
              mem_we_cmd_q <= memWrite;
              mem_pc_q     <= pc;
              cnt_q        <= '0;
              state_q      <= S_MEM_WAIT;
              if (!memWrite) begin
                mem_rd_q <= mem_rd;
                busy_q   <= 8'b1 << mem_rd;
              end
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            // Ack beats a coincident timeout.
            mem_req_q    <= 1'b0;
            mem_we_cmd_q <= 1'b0;
            busy_q       <= '0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            mem_req_q       <= 1'b0;
            mem_we_cmd_q    <= 1'b0;
            busy_q          <= '0;
            cnt_q           <= '0;
            exception_q     <= 1'b1;
            pc_redirect_q   <= 1'b1;
            redirect_addr_q <= EXC_ADDR;
            epc_q           <= mem_pc_q;
            state_q         <= S_FLUSH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_FLUSH: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we_cmd    = mem_we_cmd_q;
  assign mem_wb_rd     = mem_rd_q;
  assign busy_mask     = busy_q;
  assign pc_redirect   = pc_redirect_q;
  assign redirect_addr = redirect_addr_q;
  assign exception     = exception_q;
  assign epc           = epc_q;

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// Bench for vliw_issue_scoreboard: drives directed and random bundles, queues the
// write/redirect events each bundle must cause (with the cycle they must appear in),
// and a negedge monitor pops and compares them whenever the DUT raises one.
module tb_vliw_issue_scoreboard;
  localparam logic [31:0] EXC = 32'h00FF00FF;
  localparam int          TMO = 15;

  logic        clk, reset, issue_valid, issue_ready;
  logic [31:0] pc, branch_target, redirect_addr, epc;
  logic [2:0]  alu_rm, alu_rn, alu_rd, mem_rn, mem_rd, mem_wb_rd;
  logic        alu_regWrite, alu_undefinedInstruction, memRead, memWrite, mem_regWrite;
  logic        isBranch, isJump, mem_undefinedInstruction, branch_taken;
  logic        alu_we, mem_we, mem_req, mem_we_cmd, mem_ack, pc_redirect, exception;
  logic [7:0]  busy_mask;

  vliw_issue_scoreboard #(.EXC_ADDR(EXC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready), .pc(pc),
    .alu_rm(alu_rm), .alu_rn(alu_rn), .alu_rd(alu_rd), .alu_regWrite(alu_regWrite),
    .alu_undefinedInstruction(alu_undefinedInstruction), .mem_rn(mem_rn), .mem_rd(mem_rd),
    .memRead(memRead), .memWrite(memWrite), .mem_regWrite(mem_regWrite), .isBranch(isBranch),
    .isJump(isJump), .mem_undefinedInstruction(mem_undefinedInstruction),
    .branch_taken(branch_taken), .branch_target(branch_target), .alu_we(alu_we), .mem_we(mem_we),
    .mem_wb_rd(mem_wb_rd), .mem_req(mem_req), .mem_we_cmd(mem_we_cmd), .mem_ack(mem_ack),
    .pc_redirect(pc_redirect), .redirect_addr(redirect_addr), .exception(exception), .epc(epc),
    .busy_mask(busy_mask)
  );

  typedef struct { logic [2:0] rd; int cyc; } wb_t;
  typedef struct { logic [31:0] addr; logic exc; logic [31:0] epc; int cyc; } redir_t;

  int     alu_q[$];
  wb_t    wb_q[$];
  redir_t rd_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] r);
    logic [7:0] m;
    m = 8'h01 << r;
    return m;
  endfunction

  // Monitor: every write/redirect the DUT shows must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_we) begin
        if (alu_q.size() == 0) chk("alu_we_spurious", 32'(alu_we), 32'd0);
        else chk("alu_we_cycle", cyc, alu_q.pop_front());
      end
      if (mem_we) begin
        if (wb_q.size() == 0) chk("mem_we_spurious", 32'(mem_we), 32'd0);
        else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_cycle", cyc, w.cyc);
          chk("wb_rd", 32'(mem_wb_rd), 32'(w.rd));
          chk("wb_busy", 32'(busy_mask), 32'(onehot(w.rd)));
        end
      end
      if (pc_redirect || exception) begin
        if (rd_q.size() == 0) chk("redirect_spurious", 32'(pc_redirect | exception), 32'd0);
        else begin
          redir_t r;
          r = rd_q.pop_front();
          chk("redir_cycle", cyc, r.cyc);
          chk("redir_pulse", 32'(pc_redirect), 32'd1);
          chk("redir_exc", 32'(exception), 32'(r.exc));
          chk("redir_addr", redirect_addr, r.addr);
          if (r.exc) chk("redir_epc", epc, r.epc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; pc = 0; alu_rm = 0; alu_rn = 0; alu_rd = 0; alu_regWrite = 0;
    alu_undefinedInstruction = 0; mem_rn = 0; mem_rd = 0; memRead = 0; memWrite = 0;
    mem_regWrite = 0; isBranch = 0; isJump = 0; mem_undefinedInstruction = 0;
    branch_taken = 0; branch_target = 0; mem_ack = 0;
  endtask

  task automatic do_alu(input logic [2:0] rm, input logic [2:0] rn, input logic [2:0] rd,
                        input bit rw, input bit stray_ack);
    tick(); idle_inputs();
    pc = $urandom; alu_rm = rm; alu_rn = rn; alu_rd = rd; alu_regWrite = rw;
    mem_ack = stray_ack; issue_valid = 1;
    if (rw) alu_q.push_back(cyc);
    #1;
    chk("alu_ready", 32'(issue_ready), 32'd1);
    chk("alu_busy", 32'(busy_mask), 32'd0);
    tick(); idle_inputs(); #1;
    chk("alu_no_req", 32'(mem_req), 32'd0);
  endtask

  // ack_at: wait cycle (1-based) carrying mem_ack; 0 = never acked (timeout).
  task automatic do_mem(input bit is_store, input logic [2:0] rd, input logic [2:0] rn,
                        input int ack_at, input bit probe, input bit alu_rw, input logic [2:0] ard);
    logic [31:0] p;
    int now, nwait;
    tick(); idle_inputs();
    p = $urandom; pc = p;
    memRead = !is_store; memWrite = is_store; mem_rd = rd; mem_rn = rn;
    mem_regWrite = !is_store; alu_regWrite = alu_rw;
    alu_rd = (alu_rw && !is_store && ard == rd) ? rd + 3'd1 : ard;
    issue_valid = 1;
    now = cyc;
    nwait = (ack_at == 0) ? TMO : ack_at;
    if (alu_rw) alu_q.push_back(now);
    if (ack_at == 0) rd_q.push_back(redir_t'{addr: EXC, exc: 1'b1, epc: p, cyc: now + TMO + 1});
    else if (!is_store) wb_q.push_back(wb_t'{rd: rd, cyc: now + ack_at});
    #1 chk("mem_accept_ready", 32'(issue_ready), 32'd1);
    for (int i = 1; i <= nwait; i++) begin
      tick(); idle_inputs();
      if (probe) begin issue_valid = 1; alu_rn = rd; end
      mem_ack = (i == ack_at);
      #1;
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_cmd", 32'(mem_we_cmd), 32'(is_store));
      chk("wait_busy", 32'(busy_mask), is_store ? 32'd0 : 32'(onehot(rd)));
      if (probe) chk("hazard_stall", 32'(issue_ready), 32'd0);
    end
    tick(); idle_inputs();
    if (probe) begin issue_valid = 1; alu_rn = rd; end
    #1;
    chk("post_req", 32'(mem_req), 32'd0);
    chk("post_busy", 32'(busy_mask), 32'd0);
    if (ack_at == 0) begin
      chk("timeout_flush_ready", 32'(issue_ready), 32'd0);
      tick(); #1;
      chk("timeout_idle_ready", 32'(issue_ready), 32'd1);
    end else begin
      chk("post_ready", 32'(issue_ready), 32'd1);
    end
    tick(); idle_inputs();
  endtask

  // kind: 0 alu undef, 1 mem undef, 2 same-rd conflict, 3 jump, 4 taken branch, 5 not-taken branch
  task automatic do_flow(input int kind, input logic [31:0] p, input logic [31:0] tgt,
                         input logic [2:0] r, input bit rw);
    int now;
    bit redir;
    tick(); idle_inputs();
    pc = p; branch_target = tgt; issue_valid = 1;
    alu_rd = r; mem_rd = r + 3'd2; alu_regWrite = rw;
    now = cyc;
    redir = (kind != 5);
    case (kind)
      0: begin alu_undefinedInstruction = 1; memRead = rw; end
      1: begin mem_undefinedInstruction = 1; memWrite = 1; end
      2: begin alu_regWrite = 1; mem_regWrite = 1; mem_rd = r; end
      3: isJump = 1;
      default: begin isBranch = 1; branch_taken = (kind == 4); end
    endcase
    if (kind <= 2) rd_q.push_back(redir_t'{addr: EXC, exc: 1'b1, epc: p, cyc: now + 1});
    else begin
      if (rw) alu_q.push_back(now);
      if (redir) rd_q.push_back(redir_t'{addr: tgt, exc: 1'b0, epc: 32'd0, cyc: now + 1});
    end
    #1 chk("flow_ready", 32'(issue_ready), 32'd1);
    tick(); idle_inputs(); #1;
    chk("flow_no_req", 32'(mem_req), 32'd0);
    chk("flow_busy", 32'(busy_mask), 32'd0);
    if (redir) begin
      chk("flush_ready", 32'(issue_ready), 32'd0);
      tick(); #1;
      chk("after_flush_ready", 32'(issue_ready), 32'd1);
    end else begin
      chk("no_flush_ready", 32'(issue_ready), 32'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(issue_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy_mask), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_cmd"}, 32'(mem_we_cmd), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_wb_rd"}, 32'(mem_wb_rd), 32'd0);
    chk({tag, "_redirect"}, 32'(pc_redirect), 32'd0);
    chk({tag, "_redirect_addr"}, redirect_addr, 32'd0);
    chk({tag, "_exception"}, 32'(exception), 32'd0);
    chk({tag, "_epc"}, epc, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) tick();
    // Present a bundle during reset: it must not be accepted.
    issue_valid = 1; alu_regWrite = 1; alu_rd = 3; memRead = 1;
    #1;
    check_all_zero("reset");
    chk("reset_alu_we", 32'(alu_we), 32'd0);
    tick(); idle_inputs(); reset = 0;

    // Directed cases.
    do_alu(3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    do_mem(1'b0, 3'd5, 3'd1, 3, 1'b0, 1'b0, 3'd0);
    do_mem(1'b0, 3'd2, 3'd0, 3, 1'b1, 1'b0, 3'd0);
    do_flow(2, 32'h40, 32'h0, 3'd4, 1'b1);
    do_mem(1'b1, 3'd3, 3'd1, 0, 1'b0, 1'b0, 3'd0);
    do_mem(1'b1, 3'd3, 3'd1, TMO, 1'b0, 1'b0, 3'd0);
    do_mem(1'b0, 3'd7, 3'd6, TMO, 1'b0, 1'b1, 3'd7);
    do_flow(3, 32'h80, 32'h100, 3'd1, 1'b0);
    do_alu(3'd0, 3'd0, 3'd6, 1'b1, 1'b1);

    // Reset in the middle of a load wait abandons it.
    tick(); idle_inputs();
    pc = 32'h1234; memRead = 1; mem_regWrite = 1; mem_rd = 3'd6; issue_valid = 1;
    tick(); idle_inputs();
    tick(); #1;
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    chk("pre_reset_busy", 32'(busy_mask), 32'(onehot(3'd6)));
    reset = 1;
    tick(); #1;
    check_all_zero("midreset");
    reset = 0;
    tick(); #1;
    chk("after_reset_ready", 32'(issue_ready), 32'd1);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: do_alu(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        1: do_mem(1'b0, 3'($urandom), 3'($urandom), $urandom_range(0, TMO),
                  1'($urandom), 1'($urandom), 3'($urandom));
        2: do_mem(1'b1, 3'($urandom), 3'($urandom), $urandom_range(0, TMO),
                  1'b0, 1'($urandom), 3'($urandom));
        default: do_flow($urandom_range(0, 5), $urandom, $urandom, 3'($urandom), 1'($urandom));
      endcase
    end

    repeat (4) tick();
    chk("alu_events_left", alu_q.size(), 32'd0);
    chk("wb_events_left", wb_q.size(), 32'd0);
    chk("redirect_events_left", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
